// File: rtl/bank_linefill_mshr_ctrl.sv
// Bank-side linefill MSHR: tracks outstanding fills by set/way ID, issues one AR per
// fill through a registered slot, and retires entries on the last R beat.
module bank_linefill_mshr_ctrl #(
    parameter int MSHR_NUM = 4,
    parameter int ID_W     = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [ID_W-1:0]                 lkup_set_way_i,
    output logic                            lkup_inflight_o,
    input  logic                            alloc_valid_i,
    input  logic [ID_W-1:0]                 alloc_set_way_i,
    output logic                            alloc_ready_o,
    output logic                            biu_arvalid_o,
    input  logic                            biu_arready_i,
    output logic [ID_W-1:0]                 biu_arid_o,
    input  logic                            biu_rvalid_i,
    input  logic [ID_W-1:0]                 biu_rid_i,
    input  logic                            biu_rlast_i,
    output logic                            fill_done_valid_o,
    output logic [ID_W-1:0]                 fill_done_id_o,
    output logic [$clog2(MSHR_NUM+1)-1:0]   mshr_cnt_o,
    output logic                            err_o
);

    localparam int PTR_W = $clog2(MSHR_NUM);
    localparam int CNT_W = $clog2(MSHR_NUM+1);

    typedef enum logic [1:0] {FREE, REQ, ISSUED} ent_state_t;

    ent_state_t            state_q [MSHR_NUM];
    ent_state_t            state_d [MSHR_NUM];
    logic [ID_W-1:0]       id_q    [MSHR_NUM];
    logic [ID_W-1:0]       id_d    [MSHR_NUM];
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic                  arvalid_q, arvalid_d;
    logic [ID_W-1:0]       arid_q, arid_d;
    logic                  done_valid_q, done_valid_d;
    logic [ID_W-1:0]       done_id_q, done_id_d;
    logic                  err_q, err_d;

    logic                  free_found, dup, lkup_hit, rid_hit, req_found, alloc_fire, slot_open;
    logic [PTR_W-1:0]      free_idx, rid_idx, req_idx, cand;
    logic [CNT_W-1:0]      cnt;

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        rr_d         = rr_q;
        arvalid_d    = arvalid_q;
        arid_d       = arid_q;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        err_d        = err_q;
        free_found   = 1'b0;
        free_idx     = '0;
        dup          = 1'b0;
        lkup_hit     = 1'b0;
        rid_hit      = 1'b0;
        rid_idx      = '0;
        req_found    = 1'b0;
        req_idx      = '0;
        cand         = '0;
        cnt          = '0;

        for (int unsigned i = 0; i < MSHR_NUM; i++) begin
            if (state_q[i] == FREE) begin
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = PTR_W'(i);
                end
            end else begin
                cnt = cnt + CNT_W'(1);
                if (id_q[i] == alloc_set_way_i) dup = 1'b1;
                if (id_q[i] == lkup_set_way_i)  lkup_hit = 1'b1;
                if (state_q[i] == ISSUED && id_q[i] == biu_rid_i) begin
                    rid_hit = 1'b1;
                    rid_idx = PTR_W'(i);
                end
            end
        end

        // Round-robin scan over REQ entries; pointer arithmetic wraps since MSHR_NUM is a power of two
        for (int unsigned k = 0; k < MSHR_NUM; k++) begin
            cand = rr_q + PTR_W'(k);
            if (!req_found && state_q[cand] == REQ) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end

        alloc_fire = alloc_valid_i & free_found;
        slot_open  = ~arvalid_q | biu_arready_i;

        if (alloc_fire && !dup) begin
            state_d[free_idx] = REQ;
            id_d[free_idx]    = alloc_set_way_i;
        end

        if (slot_open) begin
            if (req_found) begin
                arvalid_d        = 1'b1;
                arid_d           = id_q[req_idx];
                state_d[req_idx] = ISSUED;
                rr_d             = req_idx + PTR_W'(1);
            end else begin
                arvalid_d = 1'b0;
            end
        end

        if (biu_rvalid_i && biu_rlast_i && rid_hit) begin
            state_d[rid_idx] = FREE;
            done_valid_d     = 1'b1;
            done_id_d        = biu_rid_i;
        end

        if ((alloc_fire && dup) || (biu_rvalid_i && !rid_hit)) err_d = 1'b1;

        alloc_ready_o   = free_found;
        lkup_inflight_o = lkup_hit | (alloc_fire & (alloc_set_way_i == lkup_set_way_i));
        mshr_cnt_o      = cnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MSHR_NUM; i++) begin
                state_q[i] <= FREE;
                id_q[i]    <= '0;
            end
            rr_q         <= '0;
            arvalid_q    <= 1'b0;
            arid_q       <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            rr_q         <= rr_d;
            arvalid_q    <= arvalid_d;
            arid_q       <= arid_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            err_q        <= err_d;
        end
    end

    assign biu_arvalid_o     = arvalid_q;
    assign biu_arid_o        = arid_q;
    assign fill_done_valid_o = done_valid_q;
    assign fill_done_id_o    = done_id_q;
    assign err_o             = err_q;

endmodule

// File: doc/bank_linefill_mshr_ctrl.md
# bank_linefill_mshr_ctrl

Bank-side linefill MSHR controller. It tracks outstanding cacheline linefills keyed by 6-bit set/way ID, issues one read-address request per linefill to the BIU, and retires entries on the last read beat. It sits between the bank issue-queue front end, which performs inflight lookup and linefill allocation, and the BIU AR/R channels. It also returns a one-cycle fill-done pulse that the issue queue uses to release waiting requests.

## Interface
Parameters:
- MSHR_NUM, 4, number of MSHR entries (≥2, power of two)
- ID_W, 6, set/way ID width (= BIU ARID/RID width)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- lkup_set_way_i  in  ID_W  set/way ID to check for an inflight linefill
- lkup_inflight_o  out  1  combinational; ID matches a non-FREE entry or an allocation firing this cycle
- alloc_valid_i  in  1  linefill allocation request
- alloc_set_way_i  in  ID_W  ID to fill
- alloc_ready_o  out  1  at least one FREE entry (registered state only)
- biu_arvalid_o  out  1  read-address valid (registered)
- biu_arready_i  in  1  read-address ready
- biu_arid_o  out  ID_W  read-address ID (registered)
- biu_rvalid_i  in  1  read-data beat valid
- biu_rid_i  in  ID_W  read-data ID
- biu_rlast_i  in  1  last beat of the line
- fill_done_valid_o  out  1  one-cycle pulse: a linefill completed
- fill_done_id_o  out  ID_W  ID of the completed linefill
- mshr_cnt_o  out  $clog2(MSHR_NUM+1)  number of non-FREE entries
- err_o  out  1  sticky protocol error

## Operation
- Each entry holds a state and an ID. The states are FREE → REQ → ISSUED → FREE.
- **Allocation.** alloc_fire = alloc_valid_i & alloc_ready_o.
  - If alloc_set_way_i matches a non-FREE entry, the allocation is accepted and dropped: no new entry is created and err_o is set.
  - Otherwise the lowest-index FREE entry becomes REQ with the ID captured.
- **AR slot.** A single registered slot drives biu_arvalid_o and biu_arid_o.
  - The slot is "open" when biu_arvalid_o=0, or when biu_arvalid_o & biu_arready_i.
  - When the slot is open and a REQ entry exists, select one round-robin starting at rr_ptr. Load its ID into biu_arid_o, set biu_arvalid_o=1, move the entry to ISSUED, and set rr_ptr = (sel+1) mod MSHR_NUM.
  - When the slot is open and no REQ entry exists, biu_arvalid_o drops to 0 and biu_arid_o holds its value.
  - While biu_arvalid_o=1 and biu_arready_i=0, biu_arid_o is stable.
- **Completion.** When biu_rvalid_i & biu_rlast_i and biu_rid_i matches an ISSUED entry:
  - the entry becomes FREE;
  - fill_done_valid_o=1 and fill_done_id_o=biu_rid_i on the next cycle.
  - Non-last beats change no state.
- **Errors.** err_o is set, and cleared only by reset, on either of:
  - a duplicate allocation;
  - biu_rvalid_i with an ID matching no ISSUED entry. That beat is ignored.
- IDs are unique among non-FREE entries, so at most one entry ever matches.

## Timing
- Reset values:
  - all entries FREE, rr_ptr=0;
  - biu_arvalid_o=0, biu_arid_o=0;
  - fill_done_valid_o=0, fill_done_id_o=0;
  - mshr_cnt_o=0, err_o=0;
  - alloc_ready_o=1, lkup_inflight_o=0 (for any lookup ID).
- Alloc→AR latency:
  - the entry is REQ at T+1 after alloc_fire at T;
  - biu_arvalid_o is high at T+2 at the earliest, with an empty slot and no older REQ entries.
- Back-to-back AR: with biu_arready_i held high, one new ARID is issued per cycle while REQ entries exist.
- rlast→done: the pulse appears on the cycle after the rlast beat, for exactly one cycle.
- Entry reuse:
  - a freed entry is visible as FREE one cycle after rlast;
  - alloc_ready_o does not see an entry freed in the same cycle.
- Full: with MSHR_NUM non-FREE entries, alloc_ready_o=0 and alloc_valid_i is ignored.
- Simultaneous alloc and completion of different entries in one cycle: both take effect. mshr_cnt_o changes by +1 − 1 = 0.
- Simultaneous lookup and alloc_fire of the same ID: lkup_inflight_o=1 (bypass).
- mshr_cnt_o updates on the same edge as the state change.
- rr_ptr wraps from MSHR_NUM−1 to 0.
- Reset asserted mid-operation:
  - every entry and output returns to its reset value immediately;
  - no fill_done pulse is generated for lost entries.

## Test plan
- **Reset and idle.** Assert reset with rvalid toggling → all outputs at reset values; alloc_ready_o=1; err_o=0.
- **Single linefill.** alloc ID 0x15 at T, arready=1 → arvalid/arid=0x15 at T+2 for one cycle. Then rvalid beats 0x15 with rlast on the 2nd beat at T+6 → fill_done_valid_o=1, id 0x15 at T+7; mshr_cnt_o goes 1→0.
- **Full and AR stall.**
  - Sequence: allocate 0x01–0x04 on consecutive cycles with arready=0.
  - Required: alloc_ready_o=0, mshr_cnt_o=4, and arid holds 0x01 while arready=0.
  - Then raise arready → arids 0x02, 0x03, 0x04 on consecutive cycles.
- **Inflight and duplicates.**
  - Lookup 0x01 while 0x01 is ISSUED → inflight=1.
  - Lookup 0x09 on the cycle 0x09 is allocated → inflight=1.
  - Duplicate alloc of 0x01 → mshr_cnt_o unchanged, err_o=1.
- **Out-of-order completion.** 0x02 completes before 0x01 → done pulses are in rlast order.
  - Alloc and completion in the same cycle → mshr_cnt_o unchanged.
  - A stray rid 0x3F → err_o=1, no pulse.
- **Reset mid-flight.** Reset with 3 entries ISSUED and arvalid high → next cycle: arvalid=0, mshr_cnt_o=0. A later rlast for an old ID → no pulse, err_o=1.
